// File: rtl/mul_share_arb.sv
// ============================================================================
// Module   : mul_share_arb
// Purpose  : Round-robin arbiter sharing one truncating multiplier among NREQ
//            requesters; registered result port with ID and completion count.
//            Define MUL_ARB_PIPE_EN to add an operand register stage ahead
//            of the multiplier (latency 2 instead of 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_share_arb #(
    parameter int DATAWIDTH = 8,
    parameter int NREQ      = 4,
    parameter int IDW       = 2
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DATAWIDTH-1:0] a_in,
    input  logic [NREQ*DATAWIDTH-1:0] b_in,
    output logic [NREQ-1:0]           gnt,
    output logic [DATAWIDTH-1:0]      mul_a,
    output logic [DATAWIDTH-1:0]      mul_b,
    input  logic [DATAWIDTH-1:0]      mul_p,
    output logic [DATAWIDTH-1:0]      res,
    output logic [IDW-1:0]            res_id,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [15:0]               ops_cnt
);

    localparam logic [NREQ-1:0] c_ONE  = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [IDW-1:0]  c_LAST = IDW'(NREQ - 1);

    logic [IDW-1:0]       r_ptr;
    logic [DATAWIDTH-1:0] r_res;
    logic [IDW-1:0]       r_res_id;
    logic                 r_res_valid;
    logic [15:0]          r_ops_cnt;

    logic                 w_out_free;
    logic                 w_retire;
    logic                 w_found;
    logic [IDW-1:0]       w_win;
    int                   w_idx;
    logic                 w_can_take;
    logic                 w_grant;
    logic [DATAWIDTH-1:0] w_sel_a;
    logic [DATAWIDTH-1:0] w_sel_b;
    logic                 w_load_res;
    logic [IDW-1:0]       w_load_id;

    assign w_out_free = !r_res_valid || res_ready;
    assign w_retire   = r_res_valid && res_ready;

    // Rotating priority search: first active request at or after r_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (int'(r_ptr) + k >= NREQ)
                w_idx = int'(r_ptr) + k - NREQ;
            else
                w_idx = int'(r_ptr) + k;
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx[IDW-1:0];
            end
        end
    end

    assign w_sel_a = a_in[w_win*DATAWIDTH +: DATAWIDTH];
    assign w_sel_b = b_in[w_win*DATAWIDTH +: DATAWIDTH];
    assign w_grant = w_found && w_can_take && !Rst;
    assign gnt     = w_grant ? (c_ONE << w_win) : '0;

`ifdef MUL_ARB_PIPE_EN
    logic [DATAWIDTH-1:0] r_opa;
    logic [DATAWIDTH-1:0] r_opb;
    logic [IDW-1:0]       r_op_id;
    logic                 r_op_valid;

    // Operand stage loads when empty or when its contents move into res.
    assign w_can_take = !r_op_valid || w_out_free;
    assign w_load_res = r_op_valid && w_out_free;
    assign w_load_id  = r_op_id;
    assign mul_a      = Rst ? '0 : r_opa;
    assign mul_b      = Rst ? '0 : r_opb;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_opa      <= '0;
            r_opb      <= '0;
            r_op_id    <= '0;
            r_op_valid <= 1'b0;
        end else if (w_grant) begin
            r_opa      <= w_sel_a;
            r_opb      <= w_sel_b;
            r_op_id    <= w_win;
            r_op_valid <= 1'b1;
        end else if (w_load_res) begin
            r_op_valid <= 1'b0;
        end
    end
`else
    assign w_can_take = w_out_free;
    assign w_load_res = w_grant;
    assign w_load_id  = w_win;
    assign mul_a      = w_grant ? w_sel_a : '0;
    assign mul_b      = w_grant ? w_sel_b : '0;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_ptr       <= '0;
            r_res       <= '0;
            r_res_id    <= '0;
            r_res_valid <= 1'b0;
            r_ops_cnt   <= '0;
        end else begin
            if (w_grant)
                r_ptr <= (w_win == c_LAST) ? '0 : w_win + 1'b1;
            // A same-cycle load keeps res_valid high while the old result retires.
            if (w_load_res) begin
                r_res       <= mul_p;
                r_res_id    <= w_load_id;
                r_res_valid <= 1'b1;
            end else if (w_retire) begin
                r_res_valid <= 1'b0;
            end
            if (w_retire)
                r_ops_cnt <= r_ops_cnt + 16'd1;
        end
    end

    assign res       = r_res;
    assign res_id    = r_res_id;
    assign res_valid = r_res_valid;
    assign ops_cnt   = r_ops_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mul_share_arb.sv
// ============================================================================
// Module   : tb_mul_share_arb
// Purpose  : Directed self-checking bench for mul_share_arb (default build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_share_arb;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int IW = 2;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req;
    logic [NR*DW-1:0] a_in;
    logic [NR*DW-1:0] b_in;
    logic [NR-1:0]   gnt;
    logic [DW-1:0]   mul_a;
    logic [DW-1:0]   mul_b;
    logic [DW-1:0]   mul_p;
    logic [DW-1:0]   res;
    logic [IW-1:0]   res_id;
    logic            res_valid;
    logic            res_ready;
    logic [15:0]     ops_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    mul_share_arb #(.DATAWIDTH(DW), .NREQ(NR), .IDW(IW)) dut (
        .Clk       (clk),
        .Rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .res       (res),
        .res_id    (res_id),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .ops_cnt   (ops_cnt)
    );

    // Shared truncating multiplier
    assign mul_p = DW'(mul_a * mul_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Requester operands: r0 3*5=15, r1 200*3=600->88, r2 7*9=63, r3 16*16=256->0
    logic [3:0] rr_gnt [5] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    int         rr_id  [5] = '{3, 0, 1, 2, 3};
    int         rr_res [5] = '{0, 15, 88, 63, 0};

    initial begin
        rst       = 1'b1;
        req       = 4'b1111;
        a_in      = {8'd16, 8'd7, 8'd200, 8'd3};
        b_in      = {8'd16, 8'd9, 8'd3,   8'd5};
        res_ready = 1'b1;

        // Reset held two cycles with all requests active
        tick();
        tick();
        check("rst_gnt",   32'(gnt), 32'd0);
        check("rst_mul_a", 32'(mul_a), 32'd0);
        check("rst_mul_b", 32'(mul_b), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_ops",   32'(ops_cnt), 32'd0);
        check("rst_res",   32'(res), 32'd0);
        rst = 1'b0;
        req = 4'b0000;
        tick();

        // Single op on requester 2
        req = 4'b0100;
        #1;
        check("single_gnt",   32'(gnt), 32'b0100);
        check("single_mul_a", 32'(mul_a), 32'd7);
        check("single_mul_b", 32'(mul_b), 32'd9);
        tick();
        check("single_res",   32'(res), 32'd63);
        check("single_id",    32'(res_id), 32'd2);
        check("single_valid", 32'(res_valid), 32'd1);

        // Round robin from ptr=3 with every requester active
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(rr_gnt[i]));
            tick();
            check($sformatf("rr_res%0d", i), 32'(res), 32'(rr_res[i]));
            check($sformatf("rr_id%0d", i),  32'(res_id), 32'(rr_id[i]));
            check($sformatf("rr_ops%0d", i), 32'(ops_cnt), 32'(i + 1));
        end
        req = 4'b0000;
        tick();
        check("rr_drain_valid", 32'(res_valid), 32'd0);
        check("rr_drain_ops",   32'(ops_cnt), 32'd6);

        // Backpressure: ptr=0, requesters 0 and 1
        req       = 4'b0011;
        res_ready = 1'b0;
        #1;
        check("bp_first_gnt", 32'(gnt), 32'b0001);
        tick();
        check("bp_first_res", 32'(res), 32'd15);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp_gnt%0d", i), 32'(gnt), 32'd0);
            tick();
            check($sformatf("bp_res%0d", i), 32'(res), 32'd15);
            check($sformatf("bp_id%0d", i),  32'(res_id), 32'd0);
            check($sformatf("bp_valid%0d", i), 32'(res_valid), 32'd1);
        end
        check("bp_ops_held", 32'(ops_cnt), 32'd6);
        res_ready = 1'b1;
        req       = 4'b0010;
        #1;
        check("bp_release_gnt", 32'(gnt), 32'b0010);
        tick();
        check("bp_release_res",   32'(res), 32'd88);
        check("bp_release_id",    32'(res_id), 32'd1);
        check("bp_release_valid", 32'(res_valid), 32'd1);
        check("bp_release_ops",   32'(ops_cnt), 32'd7);
        req = 4'b0000;
        tick();
        check("bp_drain_ops", 32'(ops_cnt), 32'd8);

        // Counter wrap: accept one op, preload counter, retire it
        req = 4'b0100;
        tick();
        req = 4'b0000;
        force dut.r_ops_cnt = 16'hFFFF;
        #1;
        release dut.r_ops_cnt;
        tick();
        check("wrap_ops",   32'(ops_cnt), 32'd0);
        check("wrap_valid", 32'(res_valid), 32'd0);

        // Reset while a result is pending
        res_ready = 1'b0;
        req       = 4'b0001;
        tick();
        check("mid_valid_before", 32'(res_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_gnt", 32'(gnt), 32'd0);
        tick();
        check("mid_rst_valid", 32'(res_valid), 32'd0);
        check("mid_rst_ops",   32'(ops_cnt), 32'd0);
        check("mid_rst_res",   32'(res), 32'd0);
        rst       = 1'b0;
        req       = 4'b0000;
        res_ready = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
